// File: rtl/klingon_scan_display.sv
// klingon_scan_display: time-multiplexed multi-digit 7-segment driver with hex/Klingon glyphs
// and a frame-atomic valid/ready load port.
module klingon_scan_display #(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 1000,
    parameter int BLANK_CYC  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load_valid,
    output logic                    load_ready,
    input  logic [4*NUM_DIGITS-1:0] load_data,
    input  logic                    mode,
    input  logic                    lzb,
    output logic [6:0]              seg,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int W  = 4 * NUM_DIGITS;
    localparam logic [6:0] HEX [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                        7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    localparam logic [6:0] KLG [16] = '{7'h63, 7'h30, 7'h36, 7'h3F, 7'h0F, 7'h49, 7'h37, 7'h5D,
                                        7'h6B, 7'h7C, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01};

    logic [DW-1:0]         div_q, div_d;
    logic [IW-1:0]         dig_q, dig_d;
    logic [W-1:0]          active_q, active_d, pend_q, pend_d;
    logic                  pflag_q, pflag_d, live_q, live_d, tick_q, tick_d;
    logic [6:0]            seg_q, seg_d;
    logic [NUM_DIGITS-1:0] an_q, an_d;
    logic                  slot_end, frame_end, xfer, allz, hide, on;
    logic [3:0]            code;
    logic [6:0]            glyph;

    assign slot_end  = div_q == DW'(SCAN_DIV - 1);
    assign frame_end = slot_end && dig_q == IW'(NUM_DIGITS - 1);
    assign xfer      = load_valid && !pflag_q;

    // A word accepted on a boundary edge only reaches pending; it is applied one frame later.
    always_comb begin
        div_d    = slot_end ? '0 : div_q + 1'b1;
        dig_d    = !slot_end ? dig_q : frame_end ? '0 : dig_q + 1'b1;
        active_d = (frame_end && pflag_q) ? pend_q : active_q;
        live_d   = live_q || (frame_end && pflag_q);
        pend_d   = xfer ? load_data : pend_q;
        pflag_d  = xfer || (pflag_q && !frame_end);
        tick_d   = frame_end;
    end

    // Outputs are computed from next-state so the registers line up with the counters.
    always_comb begin
        allz = 1'b1;
        hide = 1'b0;
        code = '0;
        for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
            allz = allz && (active_d[4*k +: 4] == 4'd0);
            if (dig_d == IW'(k)) begin
                code = active_d[4*k +: 4];
                hide = lzb && allz && (k > 0);
            end
        end
        glyph = mode ? KLG[code] : HEX[code];
        // Dark until the first word has been applied, so an unloaded block shows nothing.
        on    = live_d && (div_d >= DW'(BLANK_CYC)) && !hide;
        an_d  = on ? (NUM_DIGITS'(1) << dig_d) : '0;
        seg_d = on ? glyph : '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q    <= '0;
            dig_q    <= '0;
            active_q <= '0;
            pend_q   <= '0;
            pflag_q  <= 1'b0;
            live_q   <= 1'b0;
            tick_q   <= 1'b0;
            seg_q    <= '0;
            an_q     <= '0;
        end else begin
            div_q    <= div_d;
            dig_q    <= dig_d;
            active_q <= active_d;
            pend_q   <= pend_d;
            pflag_q  <= pflag_d;
            live_q   <= live_d;
            tick_q   <= tick_d;
            seg_q    <= seg_d;
            an_q     <= an_d;
        end
    end

    assign load_ready = !pflag_q;
    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
endmodule

// File: tb/tb_klingon_scan_display.sv
// tb_klingon_scan_display: directed, table-driven bench for the scanned display driver
// (4 digits, 8 cycles per slot, 2 blank cycles).
module tb_klingon_scan_display;
    typedef struct packed {
        logic [15:0]     data;
        logic            mode;
        logic            lzb;
        logic [3:0][6:0] g;
    } vec_t;

    logic        clk = 1'b0, reset = 1'b1, load_valid = 1'b0, mode = 1'b0, lzb = 1'b0;
    logic [15:0] load_data = '0;
    logic        load_ready, frame_tick;
    logic [6:0]  seg;
    logic [3:0]  an;
    int          cyc = 0, checks = 0, errors = 0, xfers = 0;
    vec_t        vecs [9];
    vec_t        prev;

    klingon_scan_display #(.NUM_DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2)) dut (
        .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .mode(mode), .lzb(lzb), .seg(seg), .an(an), .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, act, exp);
        end
    endtask

    // Expected display for a hand-computed glyph set at the current frame phase.
    task automatic chk_disp(input vec_t v);
        int p, dv, dg;
        logic [6:0] es;
        logic [3:0] ea;
        p  = cyc % 32;
        dv = p % 8;
        dg = p / 8;
        es = (dv >= 2) ? v.g[dg] : 7'h00;
        ea = (es != 7'h00) ? 4'(1 << dg) : 4'h0;
        chk("an", 16'(an), 16'(ea));
        chk("seg", 16'(seg), 16'(es));
    endtask

    task automatic run_vec(input vec_t v, input vec_t old);
        int n;
        load_valid = 1'b1;
        load_data  = v.data;
        tick();
        load_valid = 1'b0;
        chk("ready_drop", 16'(load_ready), 16'h0);
        n = 0;
        while (!frame_tick && n < 40) begin
            chk_disp(old);
            tick();
            n++;
        end
        chk("tick_seen", 16'(frame_tick), 16'h1);
        chk("ready_back", 16'(load_ready), 16'h1);
        mode = v.mode;
        lzb  = v.lzb;
        for (int k = 0; k < 32; k++) begin
            chk_disp(v);
            tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{16'h1234, 1'b0, 1'b0, {7'h30, 7'h6D, 7'h79, 7'h33}};
        vecs[1] = '{16'h00A7, 1'b0, 1'b1, {7'h00, 7'h00, 7'h77, 7'h70}};
        vecs[2] = '{16'h00A7, 1'b1, 1'b1, {7'h00, 7'h00, 7'h01, 7'h5D}};
        vecs[3] = '{16'h0000, 1'b0, 1'b1, {7'h00, 7'h00, 7'h00, 7'h7E}};
        vecs[4] = '{16'h0000, 1'b1, 1'b1, {7'h00, 7'h00, 7'h00, 7'h63}};
        vecs[5] = '{16'h0F0C, 1'b1, 1'b0, {7'h63, 7'h01, 7'h63, 7'h01}};
        vecs[6] = '{16'h0050, 1'b0, 1'b1, {7'h00, 7'h00, 7'h5B, 7'h7E}};
        vecs[7] = '{16'h8E96, 1'b0, 1'b0, {7'h7F, 7'h4F, 7'h7B, 7'h5F}};
        vecs[8] = '{16'h0302, 1'b1, 1'b1, {7'h00, 7'h3F, 7'h63, 7'h36}};
        prev = '0;

        tick();
        tick();
        reset = 1'b0;
        cyc   = 0;
        chk("rst_ready", 16'(load_ready), 16'h1);
        chk("rst_an", 16'(an), 16'h0);
        chk("rst_seg", 16'(seg), 16'h0);
        chk("rst_tick", 16'(frame_tick), 16'h0);
        for (int c = 1; c <= 32; c++) begin
            tick();
            chk("idle_an", 16'(an), 16'h0);
            chk("idle_seg", 16'(seg), 16'h0);
            chk("idle_tick", 16'(frame_tick), 16'(c == 32));
        end

        for (int v = 0; v < 9; v++) begin
            run_vec(vecs[v], prev);
            prev = vecs[v];
        end

        // Held load_valid with changing data, then a transfer on the boundary edge itself.
        chk("hold_start_tick", 16'(frame_tick), 16'h1);
        mode = 1'b0;
        lzb  = 1'b0;
        for (int i = 0; i < 204; i++) begin
            load_valid = (i <= 96) || (i == 159);
            load_data  = (i == 159) ? 16'h0009 : 16'(16'h1111 * (i % 10));
            if (load_valid && load_ready && i < 96) xfers++;
            case (i)
                32:  chk("hold_ready32", 16'(load_ready), 16'h1);
                33:  chk("hold_ready33", 16'(load_ready), 16'h0);
                42:  begin chk("hold_an42", 16'(an), 16'h2); chk("hold_seg42", 16'(seg), 16'h7E); end
                74:  chk("hold_seg74", 16'(seg), 16'h6D);
                106: chk("hold_seg106", 16'(seg), 16'h33);
                159: chk("bnd_ready159", 16'(load_ready), 16'h1);
                160: begin chk("bnd_ready160", 16'(load_ready), 16'h0); chk("bnd_tick160", 16'(frame_tick), 16'h1); end
                170: begin chk("bnd_an170", 16'(an), 16'h2); chk("bnd_seg170", 16'(seg), 16'h5F); end
                192: chk("bnd_ready192", 16'(load_ready), 16'h1);
                194: begin chk("bnd_an194", 16'(an), 16'h1); chk("bnd_seg194", 16'(seg), 16'h7B); end
                202: begin chk("bnd_an202", 16'(an), 16'h2); chk("bnd_seg202", 16'(seg), 16'h7E); end
                default: ;
            endcase
            tick();
        end
        chk("hold_xfers", 16'(xfers), 16'd3);

        // Reset mid-slot with a word pending.
        load_valid = 1'b1;
        load_data  = 16'h5555;
        tick();
        load_valid = 1'b0;
        chk("pre_rst_ready", 16'(load_ready), 16'h0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        cyc   = 0;
        chk("mid_rst_ready", 16'(load_ready), 16'h1);
        chk("mid_rst_an", 16'(an), 16'h0);
        chk("mid_rst_seg", 16'(seg), 16'h0);
        chk("mid_rst_tick", 16'(frame_tick), 16'h0);
        for (int c = 1; c <= 64; c++) begin
            tick();
            chk("post_rst_an", 16'(an), 16'h0);
            chk("post_rst_seg", 16'(seg), 16'h0);
            chk("post_rst_tick", 16'(frame_tick), 16'(c % 32 == 0));
        end
        chk("post_rst_ready", 16'(load_ready), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/klingon_scan_display.md
Name: klingon_scan_display

Overview:
- Parametrised multi-digit, time-multiplexed 7-segment display driver.
- Successor to the single-digit Klingon/hex segment decoder: it scans NUM_DIGITS digits and selects hex or Klingon glyphs at run time.
- New data is accepted through a valid/ready load port and applied atomically at frame boundaries, so a frame never shows a mix of old and new digits.
- Sits between a numeric datapath and the board display pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- SCAN_DIV, 1000, clock cycles per digit slot; must be at least 2.
- BLANK_CYC, 16, anti-ghosting blank cycles at the start of each slot; must be less than SCAN_DIV.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- load_valid  input  1  new display word offered.
- load_ready  output  1  block can accept a word.
- load_data  input  4*NUM_DIGITS  digit codes; digit k = bits [4k+3:4k]; digit 0 is least significant.
- mode  input  1  0 = hex glyphs, 1 = Klingon glyphs; sampled live every cycle.
- lzb  input  1  leading-zero blanking enable; sampled live.
- seg  output  7  segments {A,B,C,D,E,F,G} = seg[6:0]; active-high.
- an  output  NUM_DIGITS  digit enables; one-hot or zero; active-high.
- frame_tick  output  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset applies only on a clk edge where reset=1. Reset state:
  - div_cnt=0, dig_idx=0, active=0, pending flag=0.
  - load_ready=1, seg=0, an=0, frame_tick=0.
  - Reset mid-frame or with a word pending discards the pending word.
- Scan counters:
  - div_cnt counts 0..SCAN_DIV-1 and wraps to 0.
  - On the wrap edge, dig_idx advances (NUM_DIGITS-1 wraps to 0).
  - A frame boundary is the edge where div_cnt=SCAN_DIV-1 and dig_idx=NUM_DIGITS-1.
  - With NUM_DIGITS=1, every slot end is a frame boundary.
- seg and an are registers loaded from next-state values. In any cycle they are therefore a pure function of the current dig_idx, div_cnt, active, mode and lzb, with no extra lag.
- Output rule, with code = active digit dig_idx:
  - If div_cnt<BLANK_CYC, or the digit is blanked: an=0, seg=0.
  - Otherwise: an bit dig_idx = 1, all other an bits 0, seg = glyph(code, mode).
- Hex glyphs, codes 0..F: 7E 30 6D 79 33 5B 5F 70 7F 7B 77 1F 4E 3D 4F 47.
- Klingon glyphs:
  - Codes 0..9: 63 30 36 3F 0F 49 37 5D 6B 7C (team glyph table).
  - Codes 10..15 display a dash: 01.
- Leading-zero blanking (lzb=1): digit k>0 is blanked if it and every more-significant digit are code 0. Digit 0 is never blanked. The rule is the same in both modes.
- Load handshake:
  - Transfer occurs on an edge with load_valid=1 and load_ready=1. On that edge, pending<=load_data, the pending flag is set, and load_ready=0 from the next cycle.
  - load_data is ignored whenever load_ready=0.
  - load_valid may be held high; no more than one word is accepted per frame.
- Frame boundary edge:
  - If the pending flag is set: active<=pending, flag cleared, load_ready=1 from the next cycle.
  - frame_tick=1 for exactly the one cycle after every boundary edge, i.e. the cycle with dig_idx=0, div_cnt=0. It is also 0 in the first cycle after reset.
- Simultaneous transfer and frame boundary on the same edge: the word goes to pending only and is applied at the following boundary. The current frame keeps the old data.
- The active register changes only at a frame boundary or on reset.

Test Plan:
- Config for all scenarios: NUM_DIGITS=4, SCAN_DIV=8, BLANK_CYC=2.
- Reset, then run 32 cycles with no load:
  - an=0 in every cycle; seg=0 whenever an=0.
  - frame_tick first pulses in cycle 32 after reset release (dig_idx=0, div_cnt=0).
- Load 0x1234 with mode=0, lzb=0:
  - load_ready drops the cycle after transfer.
  - Data appears only after the next frame boundary; load_ready returns high the same cycle frame_tick pulses.
  - Following frame, in slots 0..3 at div_cnt 2..7: an=0001/30... specifically an=0001 seg=33, an=0010 seg=79, an=0100 seg=6D, an=1000 seg=30.
  - an=0 at div_cnt 0..1 of every slot.
- Load 0x00A7 with lzb=1:
  - mode=0: digits 3 and 2 blanked (an=0); digit 1 seg=77, digit 0 seg=70.
  - mode=1: digit 1 shows 01 (dash), digit 0 shows 5D.
- Load 0x0000 with lzb=1: only digit 0 lit, seg=7E in hex mode, 63 in Klingon mode.
- Hold load_valid=1 with changing data:
  - Exactly one transfer per frame.
  - A transfer on the boundary edge itself is not shown until one frame later.
- Assert reset for one cycle mid-slot with a word pending:
  - All outputs return to reset values; the pending word is never displayed; load_ready=1.
